vga_scan_driver: RTL
====================

# vga_scan_driver

Scan-side driver for the register display: generates 800x600@72 Hz VGA timing from the 50 MHz system clock, presents the current pixel coordinate (`x`, `y`) to the renderer tree, and samples the renderer's wired-OR `hit` back into registered RGB with sync outputs aligned to it. It also presents the 176-bit register bus to the renderers, frame-latched so a displayed value never changes mid-frame.

## Interface
Parameters:
- `H_VIS` 800, `H_FP` 56, `H_SYNC` 120, `H_BP` 64: horizontal timing in pixels (total 1040).
- `V_VIS` 600, `V_FP` 37, `V_SYNC` 6, `V_BP` 23: vertical timing in lines (total 666).
- `FG_RGB` 9'h1FF: foreground colour, 3:3:3.
- `BG_RGB` 9'h000: background colour.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  50 MHz pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `registers_in`  in  176  live register file bus from the CPU.
- `hit`  in  1  wired-OR renderer result for the presented (`x`, `y`).
- `x`  out  11  current column, 0..1039.
- `y`  out  11  current line, 0..665.
- `registers_out`  out  176  register bus to the renderers.
- `hsync`  out  1  horizontal sync, active-high.
- `vsync`  out  1  vertical sync, active-high.
- `rgb`  out  9  pixel colour {R[2:0], G[2:0], B[2:0]}.
- `frame_start`  out  1  one-cycle pulse aligned with the first visible pixel on `rgb`.

## Operation
- `x` increments every cycle. At 1039 it wraps to 0 and `y` increments. `y` wraps 665 -> 0 on the cycle `x` wraps.
- `active` = (`x` < 800) && (`y` < 600), computed from the stage-0 counters.
- Stage 0 (registered counters) drives `x`, `y`. `hit` is combinational from the renderers in the same cycle.
- Stage 1 registers:
  - `rgb` = `active` ? (`hit` ? FG_RGB : BG_RGB) : 0.
  - `hsync` = 1 when 856 <= `x` <= 975.
  - `vsync` = 1 when 637 <= `y` <= 642.
  - `frame_start` = (`x`==0 && `y`==0).
- `rgb` is forced to 0 outside the active area regardless of `hit`.
- All arithmetic uses 11-bit unsigned values; no signed comparisons.

## Timing
- Reset values: `x`=0, `y`=0, `hsync`=0, `vsync`=0, `rgb`=0, `frame_start`=0, snapshot register = 0.
- Latency: `rgb`, `hsync`, `vsync` and `frame_start` lag `x`/`y` by exactly 1 cycle. All four outputs are mutually aligned.
- First cycle after `rst` deasserts: `x`=0, `y`=0. One cycle later, `frame_start`=1.
- `rst` asserted mid-frame: on the next edge, counters return to 0,0 and all outputs return to their reset values. No partial line completes.
- Frame period: 1040*666 = 692640 cycles.

## Configuration
- `REG_SNAPSHOT_EN` defined:
  - The snapshot register loads `registers_in` on the cycle `x`==1039 && `y`==665 (the last cycle of the frame).
  - `registers_out` = the snapshot. A change to `registers_in` therefore becomes visible starting at the next frame's pixel (0,0).
  - Reset clears the snapshot to 0.
- `REG_SNAPSHOT_EN` undefined:
  - `registers_out` = `registers_in` combinationally.
  - No 176-bit register is instantiated.

## Structure
- Shared package `vga_pkg`: the timing constants (visible, front porch, sync and back porch per axis, plus totals), `COORD_W`=11, and the 3:3:3 colour typedef.
- Sub-module `vga_counter`: the x/y counter pair with wrap logic and `end_of_frame` output. It is instantiated once; the snapshot enable and `frame_start` derive from it.

## Test plan
- Reset release -> `x`,`y` = 0,0 on the first cycle. Next cycle: `frame_start`=1, `rgb`=0, `hsync`=0, `vsync`=0.
- Run 2 frames -> `hsync` high for exactly 120 cycles per 1040-cycle line; `vsync` high for exactly 6 lines; `frame_start` pulses at a period of 692640 cycles.
- `hit` tied 1 -> `rgb`=9'h1FF for exactly 800 cycles per line on lines 0..599, and 0 everywhere else, including blanking.
- `hit` = 1 only when `x`==10 && `y`==20 -> `rgb`=FG_RGB on exactly one cycle per frame, 1 cycle after `x`/`y` = 10/20.
- With `REG_SNAPSHOT_EN`: change `registers_in` from 0 to 176'h1 at `y`=300 -> `registers_out` stays 0 until the cycle after (1039,665), then reads 1. Without the macro: `registers_out` follows immediately.
- `rst` pulsed at `x`=500, `y`=400 -> next cycle `x`,`y`=0,0 and all outputs at reset values. The following frame's timing is identical to the post-reset run.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate width and colour type for the
// register-display scan driver.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int REG_W   = 176;

  // 800x600@72 Hz from a 50 MHz pixel clock
  localparam int VGA_H_VIS   = 800;
  localparam int VGA_H_FP    = 56;
  localparam int VGA_H_SYNC  = 120;
  localparam int VGA_H_BP    = 64;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VIS   = 600;
  localparam int VGA_V_FP    = 37;
  localparam int VGA_V_SYNC  = 6;
  localparam int VGA_V_BP    = 23;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 3:3:3 colour, packed as {R, G, B}
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;

endpackage

// File: rtl/vga_counter.sv
// Stage-0 pixel/line counter pair. end_of_frame flags the last pixel of the
// last line so the parent can act on the frame boundary.
module vga_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               end_of_frame
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               end_of_line;

  // Next-position logic: x wraps every line, y advances on x wrap
  always_comb begin
    end_of_line  = (x_q == X_LAST);
    end_of_frame = end_of_line && (y_q == Y_LAST);
    x_d          = end_of_line ? '0 : x_q + 1'b1;
    y_d          = y_q;
    if (end_of_line) begin
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: presents (x, y) to the renderers, registers their wired-OR
// hit into rgb with hsync/vsync/frame_start aligned one cycle behind x/y.
// Optional REG_SNAPSHOT_EN: registers_out is latched once per frame on the
// last pixel so renderers never see a value change mid-frame; without it the
// register bus passes straight through.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int         H_VIS   = VGA_H_VIS,
  parameter int         H_FP    = VGA_H_FP,
  parameter int         H_SYNC  = VGA_H_SYNC,
  parameter int         H_BP    = VGA_H_BP,
  parameter int         V_VIS   = VGA_V_VIS,
  parameter int         V_FP    = VGA_V_FP,
  parameter int         V_SYNC  = VGA_V_SYNC,
  parameter int         V_BP    = VGA_V_BP,
  parameter logic [8:0] FG_RGB  = 9'h1FF,
  parameter logic [8:0] BG_RGB  = 9'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   registers_in,
  input  logic               hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [REG_W-1:0]   registers_out,
  output logic               hsync,
  output logic               vsync,
  output logic [8:0]         rgb,
  output logic               frame_start
);

  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

  logic end_of_frame;
  logic active;

  rgb_t rgb_q, rgb_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frame_start_q, frame_start_d;
  // High exactly while the counters sit at (0,0): after reset or after the
  // previous frame's last pixel. Saves a pair of 11-bit zero compares.
  logic at_origin_q, at_origin_d;

  vga_counter #(
    .H_TOTAL (H_VIS + H_FP + H_SYNC + H_BP),
    .V_TOTAL (V_VIS + V_FP + V_SYNC + V_BP)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .y            (y),
    .end_of_frame (end_of_frame)
  );

  // Stage-1 next values from the stage-0 position and the renderer hit
  always_comb begin
    active        = (x < X_VIS) && (y < Y_VIS);
    rgb_d         = RGB_BLACK;
    if (active) begin
      rgb_d = hit ? rgb_t'(FG_RGB) : rgb_t'(BG_RGB);
    end
    hsync_d       = (x >= HS_START) && (x <= HS_END);
    vsync_d       = (y >= VS_START) && (y <= VS_END);
    frame_start_d = at_origin_q;
    at_origin_d   = end_of_frame;
  end

  // Stage-1 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q         <= RGB_BLACK;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      at_origin_q   <= 1'b1;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      at_origin_q   <= at_origin_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

`ifdef REG_SNAPSHOT_EN
  logic [REG_W-1:0] snap_q, snap_d;

  // Load the live bus on the last pixel so it applies from the next (0,0)
  always_comb begin
    snap_d = end_of_frame ? registers_in : snap_q;
  end

  // Frame snapshot register
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign registers_out = snap_q;
`else
  assign registers_out = registers_in;
`endif

endmodule
